// File: rtl/note_player_mc.sv
// Time-multiplexed N-voice note player: each frame strobe starts one scan that fetches
// every voice's phase delta and envelope step from a single shared synchronous ROM.
module note_player_mc #(
  parameter int                NUM_CH   = 4,
  parameter int                CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int                ROM_AW   = 8,
  parameter logic [ROM_AW-1:0] LEN_BASE = ROM_AW'(8'h80),
  parameter logic [ROM_AW-1:0] VAL_BASE = ROM_AW'(8'h84)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_frame_stb,
  input  logic                 i_load,
  input  logic [CHW-1:0]       i_ch,
  input  logic [5:0]           i_pitch,
  input  logic [4:0]           i_duration,
  input  logic [3:0]           i_instrument,
  input  logic                 i_loop,
  output logic [32*NUM_CH-1:0] o_phase_delta,
  output logic [4*NUM_CH-1:0]  o_envelope,
  output logic [NUM_CH-1:0]    o_done,
  output logic                 o_frame_done,
  output logic                 o_overrun,
  output logic                 o_busy,
  output logic [ROM_AW-1:0]    o_rom_addr,
  input  logic [15:0]          i_rom_data,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_P_LO = 3'd1, S_P_HI = 3'd2, S_LEN = 3'd3,
    S_VAL = 3'd4, S_FIN = 3'd5, S_NEXT = 3'd6
  } state_t;

  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

  state_t         state_q, state_d;
  logic [CHW-1:0] ch_q, start_ch;
  logic           slot_start, last_ch, load_ok;
  int             ci;

  logic [NUM_CH-1:0] pend_v, pend_loop, active_q, loop_q;
  logic [5:0]        pend_pitch [NUM_CH];
  logic [5:0]        pitch_q    [NUM_CH];
  logic [4:0]        pend_dur   [NUM_CH];
  logic [4:0]        rem_q      [NUM_CH];
  logic [3:0]        pend_inst  [NUM_CH];
  logic [3:0]        inst_q     [NUM_CH];
  logic [3:0]        step_q     [NUM_CH];
  logic [3:0]        len_q;

  logic [5:0] cur_pitch;
  logic [4:0] cur_rem;
  logic [3:0] cur_inst, cur_step;
  logic       cur_active, cur_loop;

  function automatic logic [3:0] nibble(input logic [15:0] d, input logic [1:0] idx);
    case (idx)
      2'd0:    nibble = d[15:12];
      2'd1:    nibble = d[11:8];
      2'd2:    nibble = d[7:4];
      default: nibble = d[3:0];
    endcase
  endfunction

  assign ci         = int'(ch_q);
  assign cur_pitch  = pitch_q[ch_q];
  assign cur_rem    = rem_q[ch_q];
  assign cur_inst   = inst_q[ch_q];
  assign cur_step   = step_q[ch_q];
  assign cur_active = active_q[ch_q];
  assign cur_loop   = loop_q[ch_q];
  assign last_ch    = (ch_q == LAST_CH);
  assign load_ok    = i_load && (int'(i_ch) < NUM_CH);
  assign o_state    = state_q;

  // A channel's slot begins on the edge that enters P_LO; pending loads are consumed there.
  assign slot_start = ((state_q == S_IDLE) && i_frame_stb) || ((state_q == S_NEXT) && !last_ch);
  assign start_ch   = (state_q == S_IDLE) ? '0 : ch_q + CHW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      if (slot_start) ch_q <= start_ch;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_frame_stb) state_d = S_P_LO;
      S_P_LO:  state_d = cur_active ? S_P_HI : S_NEXT;
      S_P_HI:  state_d = S_LEN;
      S_LEN:   state_d = S_VAL;
      S_VAL:   state_d = S_FIN;
      S_FIN:   state_d = S_NEXT;
      S_NEXT:  state_d = last_ch ? S_IDLE : S_P_LO;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_rom_addr   = '0;
    o_busy       = (state_q != S_IDLE);
    o_frame_done = (state_q == S_NEXT) && last_ch;
    case (state_q)
      S_P_LO:  if (cur_active) o_rom_addr = ROM_AW'({cur_pitch, 1'b0});
      S_P_HI:  o_rom_addr = ROM_AW'({cur_pitch, 1'b1});
      S_LEN:   o_rom_addr = LEN_BASE + ROM_AW'(cur_inst[3:2]);
      S_VAL:   o_rom_addr = VAL_BASE + ROM_AW'({cur_inst, 2'b00}) + ROM_AW'(cur_step[3:2]);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_v        <= '0;
      pend_loop     <= '0;
      active_q      <= '0;
      loop_q        <= '0;
      len_q         <= '0;
      o_done        <= '0;
      o_overrun     <= 1'b0;
      o_phase_delta <= '0;
      o_envelope    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        pend_pitch[c] <= '0;
        pend_dur[c]   <= '0;
        pend_inst[c]  <= '0;
        pitch_q[c]    <= '0;
        rem_q[c]      <= '0;
        inst_q[c]     <= '0;
        step_q[c]     <= '0;
      end
    end else begin
      o_done    <= '0;
      o_overrun <= i_frame_stb && (state_q != S_IDLE);
      if (slot_start && pend_v[start_ch]) begin
        pitch_q[start_ch]  <= pend_pitch[start_ch];
        rem_q[start_ch]    <= pend_dur[start_ch];
        inst_q[start_ch]   <= pend_inst[start_ch];
        loop_q[start_ch]   <= pend_loop[start_ch];
        step_q[start_ch]   <= '0;
        active_q[start_ch] <= 1'b1;
        pend_v[start_ch]   <= 1'b0;
      end
      // Placed after the consume so a same-cycle load to that channel stays pending.
      if (load_ok) begin
        pend_v[i_ch]     <= 1'b1;
        pend_pitch[i_ch] <= i_pitch;
        pend_dur[i_ch]   <= i_duration;
        pend_inst[i_ch]  <= i_instrument;
        pend_loop[i_ch]  <= i_loop;
      end
      case (state_q)
        S_P_LO: if (!cur_active) o_envelope[4*ci +: 4] <= '0;
        S_P_HI: o_phase_delta[32*ci +: 16] <= i_rom_data;
        S_LEN:  o_phase_delta[32*ci+16 +: 16] <= i_rom_data;
        S_VAL:  len_q <= nibble(i_rom_data, cur_inst[1:0]);
        S_FIN: begin
          o_envelope[4*ci +: 4] <= nibble(i_rom_data, cur_step[1:0]);
          if (cur_step == len_q) begin
            if (cur_loop) step_q[ch_q] <= '0;
          end else begin
            step_q[ch_q] <= cur_step + 4'd1;
          end
          if (cur_rem == '0) begin
            active_q[ch_q] <= 1'b0;
            o_done[ch_q]   <= 1'b1;
          end else begin
            rem_q[ch_q] <= cur_rem - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_player_mc.sv
// Directed bench for note_player_mc: a behavioural synchronous ROM, frame-by-frame
// stimulus, and hand-computed phase/envelope/timing expectations.
module tb_note_player_mc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_stb, load, loop_en;
  logic [1:0]   ch;
  logic [5:0]   pitch;
  logic [4:0]   duration;
  logic [3:0]   instrument;
  logic [127:0] phase_delta;
  logic [15:0]  envelope;
  logic [3:0]   done;
  logic         frame_done, overrun, busy;
  logic [7:0]   rom_addr;
  logic [15:0]  rom_data = 16'h0;
  logic [2:0]   state;

  logic [15:0]  rom [256];

  int           checks = 0;
  int           passed = 0;
  int           frame_len, ovr_cnt, rd_cnt;
  logic [3:0]   done_acc;
  logic         busy_seen;
  logic [3:0]   exp_loop1 [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd3, 4'd4};
  logic [3:0]   exp_loop0 [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  note_player_mc dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_stb  (frame_stb),
    .i_load       (load),
    .i_ch         (ch),
    .i_pitch      (pitch),
    .i_duration   (duration),
    .i_instrument (instrument),
    .i_loop       (loop_en),
    .o_phase_delta(phase_delta),
    .o_envelope   (envelope),
    .o_done       (done),
    .o_frame_done (frame_done),
    .o_overrun    (overrun),
    .o_busy       (busy),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_state      (state)
  );

  function automatic logic [3:0] env_of(input int c);
    return envelope[4*c +: 4];
  endfunction

  function automatic logic [31:0] ph_of(input int c);
    return phase_delta[32*c +: 32];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_load(input logic [1:0] c, input logic [5:0] p, input logic [4:0] d,
                         input logic [3:0] ins, input logic lp);
    ch = c; pitch = p; duration = d; instrument = ins; loop_en = lp;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Starts a frame from IDLE and follows it to o_frame_done; cycle 1 is the strobe cycle.
  task automatic run_frame(input int ovr_at, input int ld_at);
    int n;
    done_acc = '0; ovr_cnt = 0; rd_cnt = 0;
    frame_stb = 1'b1;
    n = 1;
    do begin
      @(negedge clk);
      n++;
      frame_stb = (n == ovr_at);
      load      = (n == ld_at);
      done_acc  = done_acc | done;
      if (overrun) ovr_cnt++;
      if (rom_addr != 8'h00) rd_cnt++;
    end while (!frame_done && n < 200);
    frame_stb = 1'b0;
    load      = 1'b0;
    frame_len = n;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; frame_stb = 1'b0; load = 1'b0; loop_en = 1'b0;
    ch = '0; pitch = '0; duration = '0; instrument = '0;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    rom[4]    = 16'h1111; rom[5]    = 16'h2222;
    rom[10]   = 16'h1234; rom[11]   = 16'h0056;
    rom[18]   = 16'hBEEF; rom[19]   = 16'hCAFE;
    rom[8'h80] = 16'h3000; rom[8'h81] = 16'h0200;
    rom[8'h84] = 16'h1234; rom[8'h88] = 16'h7000; rom[8'h9C] = 16'hA000;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_phase", phase_delta, 128'h0);
    check("rst_env", envelope, 16'h0);
    check("rst_done", done, 4'h0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rom_addr", rom_addr, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during LEN of ch1
    do_load(2'd1, 6'd2, 5'd3, 4'd4, 1'b0);
    frame_stb = 1'b1;
    @(negedge clk);
    frame_stb = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_len_addr", rom_addr, 8'h81);
    check("mid_phase_lo", phase_delta[47:32], 16'h1111);
    rst_n = 1'b0;
    #1;
    check("mid_rst_phase", phase_delta, 128'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", rom_addr, 8'h00);
    check("mid_rst_env", envelope, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 0);
    check("post_rst_len", frame_len, 9);
    check("post_rst_reads", rd_cnt, 0);

    // Single note, held envelope
    do_load(2'd0, 6'd5, 5'd2, 4'd6, 1'b0);
    run_frame(0, 0);
    check("single_len", frame_len, 13);
    check("single_phase", ph_of(0), 32'h00561234);
    check("single_env_f1", env_of(0), 4'hA);
    run_frame(0, 0);
    check("single_env_f2", env_of(0), 4'hA);
    check("single_done_f2", done_acc, 4'b0000);
    run_frame(0, 0);
    check("single_env_f3", env_of(0), 4'hA);
    check("single_done_f3", done_acc, 4'b0001);
    run_frame(0, 0);
    check("single_len_f4", frame_len, 9);
    check("single_env_f4", env_of(0), 4'h0);
    check("single_phase_f4", ph_of(0), 32'h00561234);

    // Looping and holding envelopes
    do_load(2'd0, 6'd5, 5'd7, 4'd0, 1'b1);
    for (int f = 0; f < 8; f++) begin
      run_frame(0, 0);
      check($sformatf("loop1_env_f%0d", f), env_of(0), exp_loop1[f]);
    end
    check("loop1_done", done_acc, 4'b0001);
    do_load(2'd0, 6'd5, 5'd7, 4'd0, 1'b0);
    for (int f = 0; f < 8; f++) begin
      run_frame(0, 0);
      check($sformatf("loop0_env_f%0d", f), env_of(0), exp_loop0[f]);
    end
    check("loop0_done", done_acc, 4'b0001);

    // Two channels in one scan
    do_load(2'd0, 6'd5, 5'd0, 4'd6, 1'b0);
    do_load(2'd3, 6'd9, 5'd0, 4'd1, 1'b0);
    run_frame(0, 0);
    check("multi_len", frame_len, 17);
    check("multi_phase0", ph_of(0), 32'h00561234);
    check("multi_phase3", ph_of(3), 32'hCAFEBEEF);
    check("multi_env", envelope, 16'h700A);
    check("multi_done", done_acc, 4'b1001);

    // Overrun strobe and a load landing on ch2's slot start
    ch = 2'd2; pitch = 6'd9; duration = 5'd1; instrument = 4'd1; loop_en = 1'b0;
    run_frame(4, 5);
    check("ovr_len", frame_len, 9);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_env", envelope, 16'h0000);
    busy_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    check("ovr_no_extra_scan", busy_seen, 1'b0);
    run_frame(0, 0);
    check("defer_len", frame_len, 13);
    check("defer_phase2", ph_of(2), 32'hCAFEBEEF);
    check("defer_env", envelope, 16'h0700);

    // Pre-emption with an overwritten pending load
    do_load(2'd0, 6'd5, 5'd1, 4'd0, 1'b1);
    run_frame(0, 0);
    check("pre_len_p1", frame_len, 17);
    check("pre_env_p1", env_of(0), 4'd1);
    check("pre_done_p1", done_acc, 4'b0100);
    do_load(2'd0, 6'd5, 5'd1, 4'd0, 1'b1);
    do_load(2'd0, 6'd9, 5'd1, 4'd0, 1'b1);
    run_frame(0, 0);
    check("pre_len_p2", frame_len, 13);
    check("pre_env_p2", env_of(0), 4'd1);
    check("pre_phase_p2", ph_of(0), 32'hCAFEBEEF);
    check("pre_done_p2", done_acc, 4'b0000);
    run_frame(0, 0);
    check("pre_env_p3", env_of(0), 4'd2);
    check("pre_done_p3", done_acc, 4'b0001);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/note_player_mc.md
Name: note_player_mc

Overview:
- Time-multiplexed, parametrised N-channel successor to the single-voice note player.
- Once per frame strobe, scans every channel and fetches each channel's pitch phase delta and envelope step from one shared synchronous ROM.
- Outputs per-channel phase deltas and 4-bit envelope levels to the oscillator/mixer bank.
- Adds per-channel load, looping envelopes, frame-overrun detection and a per-channel done pulse.

Parameters:
- NUM_CH, 4, number of voices (1..16); CHW = max(1, clog2(NUM_CH)).
- ROM_AW, 8, ROM address width.
- LEN_BASE, 8'h80, word address of the packed envelope-length table.
- VAL_BASE, 8'h84, word address of the envelope-value table (4 words per instrument).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_frame_stb  in  1  one-cycle frame tick.
- i_load  in  1  load a note into channel i_ch.
- i_ch  in  CHW  target channel for i_load.
- i_pitch  in  6  pitch-table index.
- i_duration  in  5  note length; the note plays i_duration+1 frames.
- i_instrument  in  4  instrument number.
- i_loop  in  1  1 = envelope wraps to step 0; 0 = envelope holds its last step.
- o_phase_delta  out  32*NUM_CH  channel c occupies bits [32c+31:32c].
- o_envelope  out  4*NUM_CH  channel c occupies bits [4c+3:4c].
- o_done  out  NUM_CH  one-cycle pulse when a channel finishes its final frame.
- o_frame_done  out  1  one-cycle pulse when a scan completes.
- o_overrun  out  1  one-cycle pulse when i_frame_stb arrives during a scan.
- o_busy  out  1  high while a scan is in progress.
- o_rom_addr  out  ROM_AW  ROM read address.
- i_rom_data  in  16  ROM data, valid on the cycle after its address.

Behaviour:
- Reset (async assert, sync release): all outputs and all per-channel state are 0; channels inactive; no pending loads.
- Loads:
  - i_load writes a pending slot for i_ch {pitch, duration, instrument, loop} in any cycle.
  - A second load to the same channel before it is consumed overwrites the slot.
  - Pending slots are consumed at the channel's next scan slot.
  - A load in the same cycle its channel's slot starts (IDLE/NEXT -> P_LO) is deferred to the next frame.
  - When a consume and a new load to the same channel occur in the same cycle, the new load remains pending.
- Consuming a slot: active=1, step=0; the old note is pre-empted and no o_done pulse is generated for it.
- FSM states: IDLE, P_LO, P_HI, LEN, VAL, FIN, NEXT.
  - IDLE: on i_frame_stb, set ch=0, raise o_busy, go to P_LO.
  - Channel with no pending slot and not active: envelope <= 0, phase delta unchanged, 1-cycle slot going directly to NEXT.
  - P_LO: addr = {pitch,0}.
  - P_HI: addr = {pitch,1}; capture phase[15:0].
  - LEN: addr = LEN_BASE + instrument[3:2]; capture phase[31:16].
  - VAL: addr = VAL_BASE + 4*instrument + step[3:2]; capture len = nibble(instrument[1:0]).
  - FIN: capture env = nibble(step[1:0]), then update step and duration.
  - Nibble order: nibble 0 = data[15:12], nibble 3 = data[3:0].
- An active channel's slot takes 5 cycles (P_LO..FIN).
- o_rom_addr = 0 whenever no read is issued.
- Step update in FIN:
  - If step == len: step <= 0 when loop=1, otherwise step holds.
  - Else step <= step + 1. Step is 4 bits.
- Duration update in FIN:
  - If remaining == 0: active <= 0 and o_done[ch] pulses in the cycle after FIN.
  - Else remaining <= remaining - 1.
  - An expired channel keeps its phase delta; its envelope clears to 0 at its next scan slot.
- NEXT:
  - If ch == NUM_CH-1: o_frame_done pulses, o_busy drops, go to IDLE.
  - Else ch+1, go to P_LO.
- Scan length: 6*A + 2*(NUM_CH-A) + 1 cycles, where A = number of active or pending channels.
- i_frame_stb while o_busy: ignored; o_overrun pulses; the scan continues unaffected.
- Outputs update only in the capture state of their own channel; other channels' outputs are stable during the scan.

Test Plan:
- Reset mid-scan: assert i_rst_n=0 during LEN of ch1 -> all outputs 0 immediately; after release, i_frame_stb produces a scan of 2*NUM_CH+1 cycles with no ROM reads.
- Single note: load ch0 pitch=5, dur=2, inst=6, loop=0; ROM[10]=16'h1234, ROM[11]=16'h0056, ROM[0x81]=16'h0200 (len nibble 2 = 0); ROM[0x9C]=16'hA000.
  - Frame 1 -> phase 0x00561234, env 0xA.
  - Frames 2 and 3: env = nibble(step) of 0x9C with step held at 0.
  - o_done[0] pulses after frame 3; frame 4 -> env 0.
- Loop: inst=0, len nibble=3, ROM[0x84]=16'h1234, loop=1, dur=7 -> envelope sequence 1,2,3,4,1,2,3,4.
  - Same setup with loop=0 -> 1,2,3,4,4,4,4,4.
- Multi-channel: load ch0 and ch3 at different pitches.
  - Scan takes 6+2+2+6+1 = 17 cycles.
  - Each channel's outputs match its own table entries; ch1 and ch2 envelopes stay 0.
- Overrun/deferral:
  - i_frame_stb during a scan -> o_overrun pulses once, no extra scan.
  - A load to ch2 in the cycle its slot starts -> applied in the next frame.
- Pre-emption: reload ch0 mid-note -> step restarts at 0 and no o_done pulse for the old note.
